// File: rtl/bus_arbiter_16.sv
// 16-requester round-robin bus arbiter with a one-cycle GAP after every release.
// Optional forced release after MAX_HOLD cycles is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_16 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        bus_busy,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t      r_state;
    logic [15:0] r_grant;
    logic [3:0]  r_sel;
    logic [3:0]  r_ptr;

    logic [3:0]  w_winner;
    logic        w_found;
    logic        w_force;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter_16: MAX_HOLD must be in 2..255");
    end

    // Scan downward so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        w_winner = '0;
        for (int k = 15; k >= 0; k--) begin
            if (req[r_ptr + 4'(k)]) begin
                w_winner = r_ptr + 4'(k);
            end
        end
        w_found = |req;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_timeout;

    assign w_force = (r_hold == 8'(MAX_HOLD - 1)) && (|(req & ~r_grant));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == GRANT) && req[r_sel] && w_force;
            if (r_state != GRANT) begin
                r_hold <= '0;
            end else if (r_hold != 8'(MAX_HOLD - 1)) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE, GAP: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_grant <= 16'h0001 << w_winner;
                        r_sel   <= w_winner;
                        r_ptr   <= w_winner + 4'd1;
                    end else begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                GRANT: begin
                    // A release (voluntary or forced) always passes through GAP; sel keeps the last owner.
                    if (!req[r_sel] || w_force) begin
                        r_state <= GAP;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign sel      = r_sel;
    assign bus_busy = |r_grant;

endmodule

// File: tb/tb_bus_arbiter_16.sv
// Bench for bus_arbiter_16: directed scenarios plus randomized traffic checked
// against a cycle-level reference model built on owner index and hold length.
module tb_bus_arbiter_16;

    localparam int HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        bus_busy;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    bus_arbiter_16 #(.MAX_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_grant();
        return (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
    endfunction

    task model_update(input logic [15:0] r, input logic rs);
        int i;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 16; k++) begin
                i = (m_ptr + k) % 16;
                if (r[i] && m_owner < 0) m_owner = i;
            end
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_ptr  = (m_owner + 1) % 16;
                m_held = 1;
            end
        end else begin
            m_to = 1'b0;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_held >= HOLD && (r & ~(16'h0001 << m_owner)) != 16'h0) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply inputs for one clock, advance the model, then compare just after the edge.
    task automatic step(input logic [15:0] r, input logic rs);
        req = r;
        rst = rs;
        model_update(r, rs);
        @(posedge clk);
        #1;
        chk("grant", grant, m_grant());
        chk("sel", {12'h0, sel}, 16'(m_sel));
        chk("busy", {15'h0, bus_busy}, {15'h0, (m_owner >= 0)});
        chk("timeout", {15'h0, timeout}, {15'h0, m_to});
        chk("onehot", {15'h0, ($countones(grant) <= 1)}, 16'h0001);
    endtask

    logic [15:0] rnd_req;
    logic        rnd_rst;

    initial begin
        // Reset with every requester active, then first arbitration
        step(16'hFFFF, 1'b1);
        step(16'hFFFF, 1'b1);
        chk("rst_grant", grant, 16'h0000);
        chk("rst_sel", {12'h0, sel}, 16'h0000);
        chk("rst_busy", {15'h0, bus_busy}, 16'h0000);
        step(16'hFFFF, 1'b0);
        chk("first_grant", grant, 16'h0001);
        chk("first_sel", {12'h0, sel}, 16'h0000);

        // Alternation between requesters 0 and 15
        step(16'h0000, 1'b1);
        step(16'h8001, 1'b0);
        chk("alt_g0", grant, 16'h0001);
        step(16'h8001, 1'b0);
        step(16'h8001, 1'b0);
        step(16'h8000, 1'b0);
        chk("alt_gap1", grant, 16'h0000);
        chk("alt_gap1_sel", {12'h0, sel}, 16'h0000);
        step(16'h8001, 1'b0);
        chk("alt_g15", grant, 16'h8000);
        chk("alt_sel15", {12'h0, sel}, 16'h000F);
        step(16'h8001, 1'b0);
        step(16'h8001, 1'b0);
        step(16'h0001, 1'b0);
        chk("alt_gap2", grant, 16'h0000);
        chk("alt_gap2_sel", {12'h0, sel}, 16'h000F);
        step(16'h8001, 1'b0);
        chk("alt_g0b", grant, 16'h0001);
        chk("alt_sel0b", {12'h0, sel}, 16'h0000);

        // Single requester never times out
        step(16'h0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(16'h0020, 1'b0);
            chk("solo_grant", grant, 16'h0020);
            chk("solo_to", {15'h0, timeout}, 16'h0000);
        end

        // Two contenders 2 and 9
        step(16'h0000, 1'b1);
        for (int c = 0; c < HOLD; c++) begin
            step(16'h0204, 1'b0);
            chk("hold_own2", grant, 16'h0004);
        end
        step(16'h0204, 1'b0);
        if (TO_EN) begin
            chk("to_gap1", grant, 16'h0000);
            chk("to_pulse1", {15'h0, timeout}, 16'h0001);
            for (int c = 0; c < HOLD; c++) begin
                step(16'h0204, 1'b0);
                chk("hold_own9", grant, 16'h0200);
                chk("hold_sel9", {12'h0, sel}, 16'h0009);
            end
            step(16'h0204, 1'b0);
            chk("to_gap2", grant, 16'h0000);
            chk("to_pulse2", {15'h0, timeout}, 16'h0001);
            step(16'h0204, 1'b0);
            chk("to_back2", grant, 16'h0004);
        end else begin
            for (int c = 0; c < 12; c++) begin
                step(16'h0204, 1'b0);
                chk("noto_own2", grant, 16'h0004);
            end
        end

        // Pointer wrap from 14
        step(16'h0000, 1'b1);
        step(16'h2000, 1'b0);
        chk("wrap_g13", grant, 16'h2000);
        step(16'h0000, 1'b0);
        step(16'h0011, 1'b0);
        chk("wrap_g0", grant, 16'h0001);
        step(16'h0010, 1'b0);
        chk("wrap_gap", grant, 16'h0000);
        step(16'h0010, 1'b0);
        chk("wrap_g4", grant, 16'h0010);

        // Reset pulse during owner 7's tenure
        step(16'h0000, 1'b1);
        step(16'h0080, 1'b0);
        chk("mid_g7", grant, 16'h0080);
        step(16'h0088, 1'b0);
        chk("mid_hold7", grant, 16'h0080);
        step(16'h0088, 1'b1);
        chk("mid_rst", grant, 16'h0000);
        step(16'h0088, 1'b0);
        chk("mid_g3", grant, 16'h0008);

        // Randomized traffic against the model
        rnd_req = 16'h0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: rnd_req = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    1: rnd_req = 16'($urandom);
                    default: rnd_req = 16'h0001 << $urandom_range(0, 15);
                endcase
            end
            rnd_rst = ($urandom_range(0, 63) == 0);
            step(rnd_req, rnd_rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_16.md
BUS_ARBITER_16 -- requirements
Module: bus_arbiter_16

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive grant cycles before a forced release; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 16 bits, where bit i is requester i asking for the 16-to-1 common bus.
REQ-005 The block SHALL have port grant, output, 16 bits, a registered one-hot (or zero) grant where bit i owns the bus.
REQ-006 The block SHALL have port sel, output, 4 bits, the registered bus select that drives the mux s3..s0 (sel[3]=s3).
REQ-007 The block SHALL have port bus_busy, output, 1 bit, high whenever any grant bit is high.
REQ-008 The block SHALL have port timeout, output, 1 bit, a one-cycle pulse on a forced release.

Function
REQ-009 The block SHALL implement the states IDLE, GRANT and GAP.
REQ-010 In IDLE or GAP with req nonzero, the block SHALL pick a winner round-robin: the lowest index at or above ptr, wrapping 15->0.
REQ-011 On selecting a winner, the block SHALL go to GRANT, set grant to one-hot(winner) and sel to the winner index, and set ptr to winner+1 mod 16, all registered with 1-cycle latency.
REQ-012 In IDLE or GAP with req==0, the block SHALL go to IDLE with grant=0.
REQ-013 In GRANT, grant and sel SHALL hold while req[owner] is 1.
REQ-014 In GRANT, req[owner]==0 SHALL cause a transition to GAP: grant=0 for exactly one cycle, sel holds the last owner, and there is no back-to-back grant to a different requester.
REQ-015 GAP SHALL last exactly one cycle, and arbitration in GAP SHALL follow REQ-010/REQ-012, so a new grant appears 2 cycles after the owner's req drops.
REQ-016 sel SHALL change only on entry to GRANT.
REQ-017 grant SHALL never have more than one bit set.
REQ-018 bus_busy SHALL equal |grant.
REQ-019 A hold counter SHALL clear on entry to GRANT and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until the next arbitration point; the owner re-requesting in GAP SHALL compete normally under the ptr ordering.
REQ-021 A req bit dropped before it is granted SHALL be lost, with no request latching.

Reset
REQ-022 With rst=1 at a clock edge, the block SHALL enter state IDLE with grant=0, sel=0, bus_busy=0, timeout=0, ptr=0 and hold counter=0.
REQ-023 Reset asserted during GRANT SHALL drop grant on the next edge, with no GAP cycle.
REQ-024 The block SHALL perform its first arbitration after reset on the first edge at which rst=0 and req!=0, with ptr=0 giving requester 0 first priority.

Configuration
REQ-025 The feature SHALL be controlled by the macro BUS_ARB_TIMEOUT_EN.
REQ-026 With BUS_ARB_TIMEOUT_EN defined, in GRANT with counter==MAX_HOLD-1, req[owner]==1 and any other req bit set, the block SHALL force a transition to GAP and pulse timeout for the one cycle coinciding with the GAP cycle.
REQ-027 With BUS_ARB_TIMEOUT_EN defined and no other requester pending, the owner SHALL keep the bus and the counter SHALL stay saturated.
REQ-028 Without BUS_ARB_TIMEOUT_EN, the block SHALL have no forced release, timeout SHALL be tied to 0 and the hold counter SHALL be omitted.

Verification
REQ-029 The bench SHALL cover: rst=1 with req=16'hFFFF -> grant=0, sel=0, busy=0; after rst falls -> grant=16'h0001, sel=0 one cycle later.
REQ-030 The bench SHALL cover: req=16'h8001, each owner drops req after 3 cycles then reasserts -> grants alternate 0x0001, GAP, 0x8000, GAP, 0x0001, with sel 0, 15, 0.
REQ-031 The bench SHALL cover: only req[5] held high with the macro on and MAX_HOLD=8 for 20 cycles -> grant=0x0020 continuously and timeout never pulses.
REQ-032 The bench SHALL cover: req[2] and req[9] both held high with the macro on and MAX_HOLD=8 -> owner 2 for 8 cycles, a timeout pulse with a GAP cycle, then owner 9 for 8 cycles; with the macro off, owner 2 holds indefinitely.
REQ-033 The bench SHALL cover: ptr=14 with req=16'h0011 -> wrap-around grants 0x0001 first, then 0x0010.
REQ-034 The bench SHALL cover: rst pulsed for 1 cycle mid-GRANT of owner 7 with req[3] high -> grant=0 for the reset cycle, then grant=0x0008 (ptr reset to 0).
